// File: rtl/cpu_speed_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_speed_sequencer
// Brief    : Z80 clock-enable generator (3.5/7/14/28 MHz from 28 MHz) with
//            speed changes deferred to an idle-bus CPU enable boundary.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_speed_sequencer #(
    parameter int HOLDOFF_CYCLES = 4,
    parameter int MAXSPEED       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cpu_speed_i,
    input  logic       force_slow_i,
    input  logic       bus_idle_i,
    output logic       cpu_cen_o,
    output logic [1:0] active_speed_o,
    output logic       switching_o
);

    localparam int HW = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);
    localparam logic [1:0]    MAX_CODE  = 2'(MAXSPEED);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    speed_q, speed_d;
    logic [2:0]    cnt_q,   cnt_d;
    logic [HW-1:0] hold_q,  hold_d;

    logic [1:0] target;
    logic [2:0] cnt_last;
    logic       cen;

    always_comb begin
        target = 2'd0;
        if (!force_slow_i) begin
            target = (cpu_speed_i > {2'b00, MAX_CODE}) ? MAX_CODE : cpu_speed_i[1:0];
        end
    end

    // Period is 8 >> speed, so the last count is 7 >> speed (0 at 28 MHz: always enabled).
    assign cnt_last = 3'b111 >> speed_q;
    assign cen      = (cnt_q == cnt_last);

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        hold_d  = hold_q;
        cnt_d   = cen ? 3'd0 : cnt_q + 3'd1;
        case (state_q)
            ST_RUN: begin
                if (target != speed_q) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (target == speed_q) begin
                    state_d = ST_RUN;
                end else if (cen && bus_idle_i) begin
                    speed_d = target;
                    cnt_d   = 3'd0;
                    hold_d  = HOLD_LOAD;
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                // A slow-down request must not wait out the holdoff window.
                if (force_slow_i && (speed_q != 2'd0)) begin
                    hold_d  = '0;
                    state_d = ST_PENDING;
                end else if (hold_q <= HW'(1)) begin
                    hold_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            speed_q <= 2'd0;
            cnt_q   <= 3'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    assign cpu_cen_o      = cen;
    assign active_speed_o = speed_q;
    assign switching_o    = (state_q != ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_cpu_speed_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_speed_sequencer
// Brief    : Scoreboard bench; every cpu_cen pulse is matched against a queued
//            expected (cycle, speed, switching) record.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_speed_sequencer;

    typedef struct packed {
        int         at;
        logic [1:0] spd;
        logic       sw;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst2_n = 1'b0;
    logic [3:0] cpu_speed = 4'd0;
    logic       force_slow = 1'b0;
    logic       bus_idle = 1'b1;

    logic       cen1, sw1, cen2, sw2;
    logic [1:0] spd1, spd2;

    int   cyc = 0;
    int   base = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_speed_sequencer #(.HOLDOFF_CYCLES(4), .MAXSPEED(3)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_speed_i   (cpu_speed),
        .force_slow_i  (force_slow),
        .bus_idle_i    (bus_idle),
        .cpu_cen_o     (cen1),
        .active_speed_o(spd1),
        .switching_o   (sw1)
    );

    cpu_speed_sequencer #(.HOLDOFF_CYCLES(4), .MAXSPEED(1)) u_dut_max1 (
        .clk           (clk),
        .rst_n         (rst2_n),
        .cpu_speed_i   (cpu_speed),
        .force_slow_i  (force_slow),
        .bus_idle_i    (bus_idle),
        .cpu_cen_o     (cen2),
        .active_speed_o(spd2),
        .switching_o   (sw2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per observed enable pulse.
    always @(negedge clk) begin
        if (rst_n && cen1) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL cen_main: pulse at cycle %0d, expected no pulse", cyc - base);
            end else begin
                e1 = q1.pop_front();
                if ((cyc - base) != e1.at || spd1 != e1.spd || sw1 != e1.sw) begin
                    n_fail++;
                    $display("FAIL cen_main: cycle/speed/switching got %0d/%0d/%0d, expected %0d/%0d/%0d",
                             cyc - base, spd1, sw1, e1.at, e1.spd, e1.sw);
                end
            end
        end
        if (rst2_n && cen2) begin
            n_checks++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL cen_max1: pulse at cycle %0d, expected no pulse", cyc - base);
            end else begin
                e2 = q2.pop_front();
                if ((cyc - base) != e2.at || spd2 != e2.spd || sw2 != e2.sw) begin
                    n_fail++;
                    $display("FAIL cen_max1: cycle/speed/switching got %0d/%0d/%0d, expected %0d/%0d/%0d",
                             cyc - base, spd2, sw2, e2.at, e2.spd, e2.sw);
                end
            end
        end
    end

    task automatic go(input int k);
        while (cyc < base + k) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push1(input int at, input logic [1:0] s, input logic w);
        q1.push_back('{at, s, w});
    endtask

    task automatic push2(input int at, input logic [1:0] s, input logic w);
        q2.push_back('{at, s, w});
    endtask

    task automatic do_reset(input bit with2);
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        check("reset_cen", int'(cen1), 0);
        check("reset_speed", int'(spd1), 0);
        check("reset_switching", int'(sw1), 0);
        rst_n = 1'b1;
        if (with2) rst2_n = 1'b1;
        base = cyc;
    endtask

    task automatic end_scen(input string name);
        check({name, "_queue_main"}, q1.size(), 0);
        check({name, "_queue_max1"}, q2.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Steady 3.5 MHz after reset.
        do_reset(1'b0);
        push1(7, 2'd0, 1'b0);
        push1(15, 2'd0, 1'b0);
        push1(23, 2'd0, 1'b0);
        go(10);
        check("s1_switching", int'(sw1), 0);
        go(23);
        end_scen("s1");

        // 3.5 -> 28 MHz, requested at cycle 2.
        do_reset(1'b0);
        push1(7, 2'd0, 1'b1);
        for (int c = 8; c <= 20; c++) push1(c, 2'd3, c <= 11);
        go(2);
        cpu_speed = 4'd3;
        go(3);
        check("s2_switching_pending", int'(sw1), 1);
        check("s2_speed_pending", int'(spd1), 0);
        go(12);
        check("s2_switching_done", int'(sw1), 0);
        check("s2_speed_done", int'(spd1), 3);
        go(20);
        end_scen("s2");

        // 3.5 -> 7 MHz held off by a busy bus over two boundaries.
        cpu_speed = 4'd0;
        do_reset(1'b0);
        push1(7, 2'd0, 1'b1);
        push1(15, 2'd0, 1'b1);
        push1(23, 2'd0, 1'b1);
        push1(27, 2'd1, 1'b1);
        push1(31, 2'd1, 1'b0);
        push1(35, 2'd1, 1'b0);
        go(1);
        cpu_speed = 4'd1;
        bus_idle  = 1'b0;
        go(16);
        check("s3_speed_held", int'(spd1), 0);
        check("s3_switching_held", int'(sw1), 1);
        bus_idle = 1'b1;
        go(35);
        end_scen("s3");

        // At 28 MHz, a 3->2->3 request is withdrawn while the bus is busy.
        cpu_speed = 4'd3;
        do_reset(1'b0);
        push1(7, 2'd0, 1'b1);
        for (int c = 8; c <= 20; c++) push1(c, 2'd3, (c <= 11) || (c == 15) || (c == 16));
        go(14);
        cpu_speed = 4'd2;
        bus_idle  = 1'b0;
        go(16);
        check("s4_speed_kept", int'(spd1), 3);
        cpu_speed = 4'd3;
        go(20);
        bus_idle = 1'b1;
        end_scen("s4");

        // force_slow inside holdoff bypasses it.
        do_reset(1'b0);
        push1(7, 2'd0, 1'b1);
        push1(8, 2'd3, 1'b1);
        push1(9, 2'd3, 1'b1);
        push1(17, 2'd0, 1'b0);
        push1(25, 2'd0, 1'b0);
        go(8);
        force_slow = 1'b1;
        go(12);
        check("s5_speed_slow", int'(spd1), 0);
        check("s5_switching_holdoff", int'(sw1), 1);
        go(25);
        force_slow = 1'b0;
        end_scen("s5");

        // Out-of-range request clamps to each instance's MAXSPEED.
        cpu_speed = 4'd9;
        do_reset(1'b1);
        push1(7, 2'd0, 1'b1);
        for (int c = 8; c <= 23; c++) push1(c, 2'd3, c <= 11);
        push2(7, 2'd0, 1'b1);
        push2(11, 2'd1, 1'b1);
        push2(15, 2'd1, 1'b0);
        push2(19, 2'd1, 1'b0);
        push2(23, 2'd1, 1'b0);
        go(20);
        check("s6_speed_max1", int'(spd2), 1);
        check("s6_speed_max3", int'(spd1), 3);
        go(23);
        end_scen("s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
